// File: rtl/rx_comb_decimation.sv
// rx_comb_decimation: polyphase FIR decimator (5 phases x 3 taps) with a full-precision output
module rx_comb_decimation #(
  parameter int DECIM = 5,
  parameter int TAPS = 15,
  parameter int IN_W = 11,
  parameter int COEF_W = 11,
  parameter int OUT_W = IN_W + COEF_W + 4,
  parameter logic [TAPS*COEF_W-1:0] COEFFS = {
    11'd8, 11'd24, 11'd56, 11'd120, 11'd200, 11'd280, 11'd336, 11'd352,
    11'd336, 11'd280, 11'd200, 11'd120, 11'd56, 11'd24, 11'd8
  }
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    clear,
  input  logic                    in_valid,
  input  logic signed [IN_W-1:0]  in_sample,
  output logic                    out_valid,
  output logic signed [OUT_W-1:0] out_sample,
  output logic [2:0]              phase
);
  localparam int PW = IN_W + COEF_W;
  localparam int PER = TAPS / DECIM;

  logic signed [IN_W-1:0]  hist_q [TAPS];
  logic signed [IN_W-1:0]  hist_d [TAPS];
  logic signed [OUT_W-1:0] part_q [DECIM];
  logic signed [OUT_W-1:0] part_d [DECIM];
  logic signed [OUT_W-1:0] out_q, out_d, sum;
  logic [2:0] phase_q, phase_d;
  logic frame_q, frame_d, part_v_q, part_v_d, out_v_q, out_v_d;
  logic accept, last;

  function automatic logic signed [COEF_W-1:0] coef(input int k);
    return COEFFS[k*COEF_W +: COEF_W];
  endfunction

  // Commutator, delay line, per-branch partial sums and final branch combine
  always_comb begin
    accept = in_valid & ~clear;
    last = phase_q == 3'(DECIM - 1);
    phase_d = clear ? '0 : accept ? (last ? '0 : phase_q + 3'd1) : phase_q;
    frame_d = accept & last;
    part_v_d = frame_q & ~clear;
    out_v_d = part_v_q & ~clear;
    hist_d[0] = clear ? '0 : accept ? in_sample : hist_q[0];
    for (int k = 1; k < TAPS; k++)
      hist_d[k] = clear ? '0 : accept ? hist_q[k-1] : hist_q[k];
    for (int p = 0; p < DECIM; p++) begin
      part_d[p] = '0;
      if (!clear)
        for (int j = 0; j < PER; j++)
          part_d[p] = part_d[p] + OUT_W'(PW'(coef(p + DECIM*j)) * PW'(hist_q[p + DECIM*j]));
    end
    sum = '0;
    for (int p = 0; p < DECIM; p++)
      sum = sum + part_q[p];
    out_d = out_v_d ? sum : out_q;
  end

  // State registers: history, phase, two-stage MAC pipeline and held output
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < TAPS; k++) hist_q[k] <= '0;
      for (int p = 0; p < DECIM; p++) part_q[p] <= '0;
      phase_q <= '0;
      frame_q <= 1'b0;
      part_v_q <= 1'b0;
      out_v_q <= 1'b0;
      out_q <= '0;
    end else begin
      hist_q <= hist_d;
      part_q <= part_d;
      phase_q <= phase_d;
      frame_q <= frame_d;
      part_v_q <= part_v_d;
      out_v_q <= out_v_d;
      out_q <= out_d;
    end
  end

  assign out_valid = out_v_q;
  assign out_sample = out_q;
  assign phase = phase_q;
endmodule

// File: tb/tb_rx_comb_decimation.sv
// tb_rx_comb_decimation: directed checks of the decimating FIR against hand-computed outputs
module tb_rx_comb_decimation;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic clear = 1'b0;
  logic in_valid = 1'b0;
  logic signed [10:0] in_sample = '0;
  logic out_valid;
  logic signed [25:0] out_sample;
  logic [2:0] phase;
  int n_cmp = 0;
  int n_bad = 0;
  int due = -1;
  int eph = 0;
  int exp_q[$];

  always #5 clk = ~clk;

  rx_comb_decimation dut (
    .clk(clk),
    .rst_n(rst_n),
    .clear(clear),
    .in_valid(in_valid),
    .in_sample(in_sample),
    .out_valid(out_valid),
    .out_sample(out_sample),
    .phase(phase)
  );

  task automatic check(input string tag, input logic signed [31:0] got, input logic signed [31:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
    end
  endtask

  // One cycle: check what the previous edges produced, then drive the next edge's inputs
  task automatic tick(input logic v, input int s, input logic c);
    int e;
    @(negedge clk);
    check("out_valid", 32'(out_valid), 32'(due == 0));
    if (due == 0) begin
      e = exp_q.size() > 0 ? exp_q.pop_front() : 32'h7fffffff;
      check("out_sample", out_sample, e);
    end
    check("phase", 32'(phase), eph);
    in_valid = v;
    in_sample = 11'(s);
    clear = c;
    if (c) begin
      due = -1;
      eph = 0;
    end else if (v) begin
      due = (eph == 4) ? 2 : (due >= 0 ? due - 1 : -1);
      eph = (eph + 1) % 5;
    end else if (due >= 0) begin
      due--;
    end
  endtask

  task automatic feed(input int first, input int rest, input int n, input int gapmax);
    for (int i = 0; i < n; i++) begin
      repeat ($urandom_range(0, gapmax)) tick(1'b0, 77, 1'b0);
      tick(1'b1, i == 0 ? first : rest, 1'b0);
    end
  endtask

  task automatic flush();
    repeat (4) tick(1'b0, 0, 1'b0);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    check("rst_out_sample", out_sample, 0);
    // impulse, continuous accepts
    exp_q = '{200, 280, 8, 0, 0};
    feed(1, 0, 25, 0);
    flush();
    // DC 100
    tick(1'b0, 0, 1'b1);
    exp_q = '{40800, 199200, 240000, 240000};
    feed(100, 100, 20, 0);
    flush();
    // negative full scale
    tick(1'b0, 0, 1'b1);
    exp_q = '{-417792, -2039808, -2457600, -2457600};
    feed(-1024, -1024, 20, 0);
    flush();
    // bursty impulse
    tick(1'b0, 0, 1'b1);
    exp_q = '{200, 280, 8, 0, 0};
    feed(1, 0, 25, 3);
    flush();
    // clear mid-frame (with in_valid high), then clear cancelling a completed frame
    tick(1'b0, 0, 1'b1);
    feed(100, 100, 3, 0);
    tick(1'b1, 100, 1'b1);
    feed(100, 100, 5, 0);
    tick(1'b1, 100, 1'b1);
    exp_q = '{40800, 199200, 240000, 240000};
    feed(100, 100, 20, 0);
    flush();
    // async reset between the 5th accept and its strobe
    tick(1'b0, 0, 1'b1);
    feed(100, 100, 5, 0);
    @(negedge clk);
    in_valid = 1'b0;
    clear = 1'b0;
    #1 rst_n = 1'b0;
    #1;
    check("rst_mid_out_valid", 32'(out_valid), 0);
    check("rst_mid_out_sample", out_sample, 0);
    check("rst_mid_phase", 32'(phase), 0);
    due = -1;
    eph = 0;
    @(negedge clk);
    rst_n = 1'b1;
    exp_q = '{40800, 199200};
    feed(100, 100, 10, 0);
    flush();
    check("expected_left", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
